osc_phase_reset_sched: RTL and testbench

- Slot sequencer and phase-reset scheduler for the time-multiplexed oscillator datapath.
- Generates the {voice, osc} slot index that walks every oscillator of every voice once per frame.
- Accepts note-on phase-reset requests from the voice allocator and queues one per voice.
- Drives the per-voice accumulator-zero mask so each reset lands on a whole frame boundary; no oscillator is reset mid-frame.

---
 rtl/osc_sched_pkg.sv | 17 +
 rtl/osc_slot_counter.sv | 42 ++++
 rtl/osc_phase_reset_sched.sv | 105 ++++++++++
 tb/tb_osc_phase_reset_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/osc_sched_pkg.sv
// Shared types and constants for the oscillator slot sequencer and phase-reset scheduler.
package osc_sched_pkg;

  localparam int MERGE_CNT_W = 16;
  localparam int PKG_V_WIDTH = 3;
  localparam int PKG_O_WIDTH = 2;

  typedef struct packed {
    logic [PKG_V_WIDTH-1:0] voice;
    logic [PKG_O_WIDTH-1:0] osc;
  } slot_t;

  function automatic int slot_max(input int voices, input int v_osc);
    return voices * v_osc - 1;
  endfunction

endpackage

// File: rtl/osc_slot_counter.sv
// Wrapping {voice, osc} slot counter with enable; flags slot 0 and the last slot of the frame.
module osc_slot_counter
  import osc_sched_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic               sCLK_XVXOSC,
  input  logic               reset_data_N,
  input  logic               run,
  output logic [V_WIDTH-1:0] vx,
  output logic [O_WIDTH-1:0] ox,
  output logic               frame_start,
  output logic               last_slot
);

  localparam int S_W = V_WIDTH + O_WIDTH;
  localparam logic [S_W-1:0] SLOT_LAST = S_W'(slot_max(VOICES, V_OSC));

  logic [S_W-1:0] slot_p0;
  logic [S_W-1:0] slot_nxt;

  // last_slot is the frame-boundary event: only meaningful while the counter advances
  assign last_slot = run && (slot_p0 == SLOT_LAST);
  assign slot_nxt  = last_slot ? '0 : slot_p0 + 1'b1;

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
    if (!reset_data_N) begin
      slot_p0     <= '0;
      frame_start <= 1'b1;
    end else if (run) begin
      slot_p0     <= slot_nxt;
      frame_start <= (slot_nxt == '0);
    end
  end

  assign vx = slot_p0[S_W-1:O_WIDTH];
  assign ox = slot_p0[O_WIDTH-1:0];

endmodule

// File: rtl/osc_phase_reset_sched.sv
// Phase-reset scheduler: queues one note-on reset per voice and releases them as whole-frame accumulator clears.
// Optional OSC_RESET_MERGE_CNT_EN adds a saturating count of requests merged into an already-pending voice.
module osc_phase_reset_sched
  import osc_sched_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic               sCLK_XVXOSC,
  input  logic               reset_data_N,
  input  logic               run,
  input  logic               req_valid,
  input  logic [V_WIDTH-1:0] req_voice,
  output logic               req_ready,
  output logic [V_WIDTH-1:0] vx,
  output logic [O_WIDTH-1:0] ox,
  output logic               frame_start,
  output logic [VOICES-1:0]  osc_accum_zero,
  output logic               busy,
  output logic               err_bad_voice
`ifdef OSC_RESET_MERGE_CNT_EN
  ,
  output logic [MERGE_CNT_W-1:0] merge_cnt
`endif
);

  localparam logic [V_WIDTH:0] VOICE_LIM = (V_WIDTH+1)'(VOICES);

  logic              boundary;
  logic              rdy_p0;
  logic              acc;
  logic              voice_ok;
  logic [VOICES-1:0] req_mask;
  logic [VOICES-1:0] pending_p0;
  logic [VOICES-1:0] pending_nxt;
  logic [VOICES-1:0] zero_nxt;

  osc_slot_counter #(
    .VOICES (VOICES),
    .V_OSC  (V_OSC),
    .V_WIDTH(V_WIDTH),
    .O_WIDTH(O_WIDTH)
  ) u_slot (
    .sCLK_XVXOSC (sCLK_XVXOSC),
    .reset_data_N(reset_data_N),
    .run         (run),
    .vx          (vx),
    .ox          (ox),
    .frame_start (frame_start),
    .last_slot   (boundary)
  );

  assign req_ready = rdy_p0;
  assign acc       = req_valid && rdy_p0;
  assign voice_ok  = {1'b0, req_voice} < VOICE_LIM;

  always_comb begin
    req_mask = '0;
    for (int v = 0; v < VOICES; v++)
      req_mask[v] = acc && voice_ok && (req_voice == V_WIDTH'(v));
  end

  // A request on the boundary cycle joins the frame being launched rather than waiting a frame
  always_comb begin
    pending_nxt = pending_p0 | req_mask;
    zero_nxt    = osc_accum_zero;
    if (boundary) begin
      zero_nxt    = pending_nxt;
      pending_nxt = '0;
    end
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
    if (!reset_data_N) begin
      rdy_p0         <= 1'b0;
      pending_p0     <= '0;
      osc_accum_zero <= '0;
      busy           <= 1'b0;
      err_bad_voice  <= 1'b0;
    end else begin
      rdy_p0         <= 1'b1;
      pending_p0     <= pending_nxt;
      osc_accum_zero <= zero_nxt;
      busy           <= (|pending_nxt) || (|zero_nxt);
      err_bad_voice  <= acc && !voice_ok;
    end
  end

`ifdef OSC_RESET_MERGE_CNT_EN
  function automatic logic [MERGE_CNT_W-1:0] sat_inc(input logic [MERGE_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic merge_hit;
  assign merge_hit = |(pending_p0 & req_mask);

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
    if (!reset_data_N) merge_cnt <= '0;
    else if (merge_hit) merge_cnt <= sat_inc(merge_cnt);
  end
`endif

endmodule

// File: tb/tb_osc_phase_reset_sched.sv
// Randomized scoreboard bench for osc_phase_reset_sched against a frame-level reference model.
module tb_osc_phase_reset_sched;
  import osc_sched_pkg::*;

  logic       sCLK_XVXOSC = 1'b0;
  logic       reset_data_N;
  logic       run;
  logic       req_valid;
  logic [2:0] req_voice;
  logic       req_ready;
  logic [2:0] vx;
  logic [1:0] ox;
  logic       frame_start;
  logic [7:0] osc_accum_zero;
  logic       busy;
  logic       err_bad_voice;
`ifdef OSC_RESET_MERGE_CNT_EN
  logic [15:0] merge_cnt;
`endif

  always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

  osc_phase_reset_sched #(
    .VOICES(8), .V_OSC(4), .V_WIDTH(3), .O_WIDTH(2)
  ) dut (
    .sCLK_XVXOSC   (sCLK_XVXOSC),
    .reset_data_N  (reset_data_N),
    .run           (run),
    .req_valid     (req_valid),
    .req_voice     (req_voice),
    .req_ready     (req_ready),
    .vx            (vx),
    .ox            (ox),
    .frame_start   (frame_start),
    .osc_accum_zero(osc_accum_zero),
    .busy          (busy),
    .err_bad_voice (err_bad_voice)
`ifdef OSC_RESET_MERGE_CNT_EN
    ,
    .merge_cnt     (merge_cnt)
`endif
  );

  typedef struct {
    slot_t      slot;
    logic       fs;
    logic [7:0] z;
    logic       busy;
    logic       err;
    logic       rdy;
    logic [15:0] mc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: time is counted in running cycles since reset, frames are 32 of them,
  // and the voices requested during frame F are exactly the ones cleared throughout frame F+1.
  int         total = 0;
  bit [7:0]   reqs[int];
  bit         m_ready = 1'b0;
  int         merges = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit [7:0] frame_reqs(input int f);
    return reqs.exists(f) ? reqs[f] : 8'h00;
  endfunction

  function automatic exp_t exp_now();
    exp_t e;
    int   nf = total / 32;
    int   s  = total % 32;
    e.slot.voice = 3'(s / 4);
    e.slot.osc   = 2'(s % 4);
    e.fs   = (s == 0);
    e.z    = (nf > 0) ? frame_reqs(nf - 1) : 8'h00;
    e.busy = (frame_reqs(nf) != 0) || (e.z != 0);
    e.err  = 1'b0;
    e.rdy  = m_ready;
    e.mc   = 16'(merges);
    return e;
  endfunction

  task automatic model_step();
    if (!reset_data_N) begin
      total   = 0;
      reqs.delete();
      m_ready = 1'b0;
      merges  = 0;
    end else begin
      int f = total / 32;
      if (req_valid && m_ready) begin
        bit [7:0] m = 8'b1 << req_voice;
        if ((frame_reqs(f) & m) != 0 && merges < 65535) merges++;
        reqs[f] = frame_reqs(f) | m;
      end
      m_ready = 1'b1;
      if (run) total++;
    end
    expq.push_back(exp_now());
  endtask

  task automatic cyc(input bit r, input bit rv, input logic [2:0] v, input bit rn);
    @(negedge sCLK_XVXOSC);
    reset_data_N = rn;
    run          = r;
    req_valid    = rv;
    req_voice    = v;
    if (!rn) begin
      #1;
      chk("rst_vx", 32'(vx), 32'd0);
      chk("rst_ox", 32'(ox), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd1);
      chk("rst_accum_zero", 32'(osc_accum_zero), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_bad_voice), 32'd0);
    end
    model_step();
  endtask

  task automatic run_to_slot(input int s);
    for (int i = 0; i < 64 && (total % 32) != s; i++) cyc(1, 0, 3'd0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 3'd0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge sCLK_XVXOSC);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("vx", 32'(vx), 32'(e.slot.voice));
        chk("ox", 32'(ox), 32'(e.slot.osc));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("osc_accum_zero", 32'(osc_accum_zero), 32'(e.z));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("err_bad_voice", 32'(err_bad_voice), 32'(e.err));
        chk("req_ready", 32'(req_ready), 32'(e.rdy));
`ifdef OSC_RESET_MERGE_CNT_EN
        chk("merge_cnt", 32'(merge_cnt), 32'(e.mc));
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset_data_N = 1'b0;
    run          = 1'b0;
    req_valid    = 1'b0;
    req_voice    = 3'd0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 3'd0, 0);

    // Free-running slot walk over two frames
    for (int i = 0; i < 64; i++) cyc(1, 0, 3'd0, 1);

    // Single request mid-frame
    run_to_slot(10);
    cyc(1, 1, 3'd5, 1);
    idle(80);

    // Request on the last slot, then again while its clear is active
    run_to_slot(31);
    cyc(1, 1, 3'd2, 1);
    run_to_slot(4);
    cyc(1, 1, 3'd2, 1);
    idle(80);

    // Repeated requests for one voice within a frame merge
    run_to_slot(3);
    cyc(1, 1, 3'd7, 1);
    cyc(1, 0, 3'd0, 1);
    cyc(1, 1, 3'd7, 1);
    run_to_slot(20);
    cyc(1, 1, 3'd7, 1);
    idle(70);

    // Requests keep accumulating while the counter is frozen
    run_to_slot(20);
    for (int i = 0; i < 20; i++) cyc(0, (i % 5) < 2, 3'(i % 2), 1);
    idle(50);

    // Reset mid-frame discards a pending request
    run_to_slot(5);
    cyc(1, 1, 3'd4, 1);
    run_to_slot(17);
    cyc(1, 0, 3'd0, 0);
    cyc(1, 1, 3'd4, 0);
    cyc(1, 0, 3'd0, 1);
    idle(70);

    // Randomized traffic with occasional run stalls and resets
    for (int i = 0; i < 2000; i++) begin
      bit r  = ($urandom % 8) != 0;
      bit rv = ($urandom % 4) == 0;
      bit rn = ($urandom % 400) != 0;
      cyc(r, rv, 3'($urandom % 8), rn);
    end
    cyc(1, 0, 3'd0, 1);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge sCLK_XVXOSC);
    #3;
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
